// File: rtl/gain_sched_pkg.sv
// ============================================================================
// Module   : gain_sched_pkg
// Purpose  : Shared types and default widths for the gain scheduler.
//            gain_cmd_t is one queued gain command: timed flag, target
//            timestamp and gain value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gain_sched_pkg;

  localparam int c_gain_w     = 16;
  localparam int c_ts_w       = 64;
  localparam int c_depth_log2 = 3;

  // "time" is reserved in SystemVerilog, so the timestamp field is named ts.
  typedef struct packed {
    logic                timed;
    logic [c_ts_w-1:0]   ts;
    logic [c_gain_w-1:0] gain;
  } gain_cmd_t;

  localparam int c_cmd_w = $bits(gain_cmd_t);

endpackage

`default_nettype wire

// File: rtl/gain_cmd_fifo.sv
// ============================================================================
// Module   : gain_cmd_fifo
// Purpose  : Register-based FIFO of gain commands (gain_cmd_t, packed).
//            No bypass: a pushed entry appears at head_o the next cycle.
//            Simultaneous push and pop are both honoured. clear_i empties
//            the FIFO and overrides any push/pop in the same cycle.
// Ports    : clk_i, rst_ni       - clock, async active-low reset
//            push_i, data_i      - write request and command (ignored if full)
//            pop_i               - drop head (ignored if empty)
//            clear_i             - discard all entries
//            head_o              - oldest entry (valid when ~empty_o)
//            count_o, full_o, empty_o - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gain_cmd_fifo
  import gain_sched_pkg::*;
#(
  parameter int DEPTH_LOG2 = c_depth_log2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [c_cmd_w-1:0]    data_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  output logic [c_cmd_w-1:0]    head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int                  c_depth    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_cnt = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] c_cnt_one  = 1;
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = 1;

  gain_cmd_t                mem_q [c_depth];
  logic [DEPTH_LOG2-1:0]    wr_ptr_q;
  logic [DEPTH_LOG2-1:0]    rd_ptr_q;
  logic [DEPTH_LOG2:0]      count_q;
  logic                     w_do_push;
  logic                     w_do_pop;

  assign full_o    = (count_q == c_full_cnt);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign w_do_push = push_i & ~full_o & ~clear_i;
  assign w_do_pop  = pop_i & ~empty_o & ~clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + c_ptr_one;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
      if (w_do_push && !w_do_pop)      count_q <= count_q + c_cnt_one;
      else if (!w_do_push && w_do_pop) count_q <= count_q - c_cnt_one;
    end
  end

  // Storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_ptr_q] <= gain_cmd_t'(data_i);
  end

endmodule

`default_nettype wire

// File: rtl/gain_sched_ctrl.sv
// ============================================================================
// Module   : gain_sched_ctrl
// Purpose  : Queues gain commands and applies them only at packet
//            boundaries. The first beat of a packet is held while the queue
//            head is eligible; each held cycle applies (pops) one command.
//            The beat passes in the first cycle with no eligible head.
// Ports    : ce_clk, ce_rst_n            - clock, async active-low reset
//            cmd_valid/ready, cmd_gain,
//            cmd_timed, cmd_time         - command push interface
//            flush                       - discard queued commands
//            in_tvalid/tlast/has_time/
//            in_time, in_tready          - upstream stream
//            out_tvalid, out_tready      - downstream stream
//            gain, gain_update, late     - gain output and event pulses
//            queue_count                 - queue occupancy
// Note     : GAIN_W and TS_W must equal the gain_cmd_t field widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gain_sched_ctrl
  import gain_sched_pkg::*;
#(
  parameter int                GAIN_W     = c_gain_w,
  parameter int                DEPTH_LOG2 = c_depth_log2,
  parameter int                TS_W       = c_ts_w,
  parameter logic [GAIN_W-1:0] INIT_GAIN  = 1
) (
  input  logic                ce_clk,
  input  logic                ce_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [GAIN_W-1:0]   cmd_gain,
  input  logic                cmd_timed,
  input  logic [TS_W-1:0]     cmd_time,
  input  logic                flush,
  input  logic                in_tvalid,
  input  logic                in_tlast,
  input  logic                in_has_time,
  input  logic [TS_W-1:0]     in_time,
  output logic                in_tready,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic [GAIN_W-1:0]   gain,
  output logic                gain_update,
  output logic                late,
  output logic [DEPTH_LOG2:0] queue_count
);

  logic              sop_q, sop_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              upd_q, upd_d;
  logic              late_q, late_d;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_eligible;
  logic               w_stall;
  logic               w_apply;
  logic [c_cmd_w-1:0] w_head_vec;
  gain_cmd_t          w_head;

  assign cmd_ready = ~w_full & ~flush;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_head    = gain_cmd_t'(w_head_vec);

  gain_cmd_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (ce_clk),
    .rst_ni  (ce_rst_n),
    .push_i  (w_push),
    .data_i  ({cmd_timed, cmd_time, cmd_gain}),
    .pop_i   (w_apply),
    .clear_i (flush),
    .head_o  (w_head_vec),
    .count_o (queue_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // A timed head needs a timestamped packet at or past its target time;
  // untimed heads are satisfied by any packet start.
  always_comb begin
    w_eligible = 1'b1;
    if (w_head.timed) begin
      w_eligible = in_has_time & (in_time >= w_head.ts);
    end
  end

  // Stall ignores out_tready so commands still apply while downstream is busy.
  assign w_stall    = sop_q & in_tvalid & ~w_empty & w_eligible;
  assign w_apply    = w_stall & ~flush;
  assign in_tready  = out_tready & ~w_stall;
  assign out_tvalid = in_tvalid & ~w_stall;

  always_comb begin
    sop_d  = sop_q;
    gain_d = gain_q;
    upd_d  = 1'b0;
    late_d = 1'b0;
    if (in_tvalid && in_tready) begin
      sop_d = in_tlast;
    end
    if (w_apply) begin
      gain_d = w_head.gain;
      upd_d  = 1'b1;
      late_d = w_head.timed & (in_time > w_head.ts);
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      sop_q  <= 1'b1;
      gain_q <= INIT_GAIN;
      upd_q  <= 1'b0;
      late_q <= 1'b0;
    end else begin
      sop_q  <= sop_d;
      gain_q <= gain_d;
      upd_q  <= upd_d;
      late_q <= late_d;
    end
  end

  assign gain        = gain_q;
  assign gain_update = upd_q;
  assign late        = late_q;

endmodule

`default_nettype wire

// File: tb/tb_gain_sched_ctrl.sv
// ============================================================================
// Module   : tb_gain_sched_ctrl
// Purpose  : Scoreboard bench for gain_sched_ctrl. The driver predicts, per
//            packet, which queued commands take effect and pushes the gain
//            every beat must carry; a monitor checks each transferred beat.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gain_sched_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_gain = '0;
  logic        cmd_timed = 1'b0;
  logic [63:0] cmd_time = '0;
  logic        flush = 1'b0;
  logic        in_tvalid = 1'b0;
  logic        in_tlast = 1'b0;
  logic        in_has_time = 1'b0;
  logic [63:0] in_time = '0;
  logic        in_tready;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic [15:0] gain;
  logic        gain_update;
  logic        late;
  logic [3:0]  queue_count;

  always #5 clk = ~clk;

  gain_sched_ctrl #(
    .GAIN_W(16), .DEPTH_LOG2(3), .TS_W(64), .INIT_GAIN(16'd1)
  ) dut (
    .ce_clk(clk), .ce_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_gain(cmd_gain),
    .cmd_timed(cmd_timed), .cmd_time(cmd_time), .flush(flush),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_has_time(in_has_time),
    .in_time(in_time), .in_tready(in_tready), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .gain(gain), .gain_update(gain_update),
    .late(late), .queue_count(queue_count)
  );

  // Reference model: queued commands and the gain currently in force.
  typedef struct {
    logic        timed;
    logic [63:0] ts;
    logic [15:0] g;
  } mcmd_t;
  mcmd_t mq[$];
  logic [15:0] m_gain = 16'd1;

  typedef struct {
    logic [15:0] g;
    bit          first;
    int          n_upd;
    int          n_late;
  } exp_t;
  exp_t expq[$];
  exp_t e_mon;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;
  int late_cnt = 0;
  int ready_mode = 0;  // 0 manual, 1 always ready, 2 random ready

  task automatic chk(input string name, input longint unsigned got, input longint unsigned req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) out_tready = 1'b1;
      else if (ready_mode == 2) out_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every transferred beat is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      upd_cnt  += int'(gain_update);
      late_cnt += int'(late);
      if (out_tvalid && out_tready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e_mon = expq.pop_front();
          chk("beat_gain", gain, e_mon.g);
          if (e_mon.first) begin
            chk("gain_update_pulses", upd_cnt, e_mon.n_upd);
            chk("late_pulses", late_cnt, e_mon.n_late);
            upd_cnt  = 0;
            late_cnt = 0;
          end
        end
      end
    end
  end

  task automatic push_cmd(input logic timed, input logic [63:0] t, input logic [15:0] g);
    bit    acc;
    mcmd_t c;
    acc = (mq.size() < DEPTH);
    cmd_valid = 1'b1; cmd_timed = timed; cmd_time = t; cmd_gain = g;
    #1;
    chk("cmd_ready", cmd_ready, acc);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (acc) begin
      c.timed = timed; c.ts = t; c.g = g;
      mq.push_back(c);
    end
  endtask

  // gap_after >= 0: after that beat, idle one cycle and push an untimed gap_gain.
  // flush_first: pulse flush with the first beat. probe: attempt a push
  // on the first beat while the queue is full.
  task automatic send_packet(input int n, input bit has, input logic [63:0] t,
                             input int gap_after, input logic [15:0] gap_gain,
                             input bit flush_first, input bit probe);
    int   napp, nl, cyc;
    bit   done;
    exp_t e;
    if (flush_first) mq.delete();
    napp = 0; nl = 0;
    while (mq.size() > 0) begin
      if (mq[0].timed && !(has && t >= mq[0].ts)) break;
      if (mq[0].timed && t > mq[0].ts) nl++;
      m_gain = mq[0].g;
      napp++;
      void'(mq.pop_front());
    end
    for (int i = 0; i < n; i++) begin
      e.g = m_gain; e.first = (i == 0); e.n_upd = napp; e.n_late = nl;
      expq.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      in_tvalid = 1'b1;
      in_tlast  = (i == n - 1);
      in_has_time = (i == 0) ? has : 1'($urandom_range(0, 1));
      in_time   = (i == 0) ? t : {32'($urandom), 32'($urandom)};
      if (i == 0 && flush_first) flush = 1'b1;
      if (i == 0 && probe) begin
        cmd_valid = 1'b1; cmd_timed = 1'b0; cmd_gain = 16'hBEEF;
        #1;
        chk("cmd_ready_full_with_apply", cmd_ready, 0);
      end
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 200) begin
        @(negedge clk);
        if (in_tvalid && in_tready) done = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == 1 && i == 0) begin
          if (flush_first) begin
            flush = 1'b0;
            chk("count_after_flush", queue_count, 0);
          end
          if (probe) begin
            cmd_valid = 1'b0;
            chk("count_after_apply_at_full", queue_count, DEPTH - 1);
          end
        end
      end
      if (!done) chk("beat_transfer_timeout", 0, 1);
      else if (i == 0 && ready_mode == 1 && !flush_first)
        chk("first_beat_latency", cyc, napp + 1);
      if (i == gap_after && i < n - 1) begin
        in_tvalid = 1'b0;
        push_cmd(1'b0, 64'd0, gap_gain);
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset_gain", gain, 1);
    chk("reset_count", queue_count, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_gain_update", gain_update, 0);
    chk("reset_late", late, 0);
    chk("in_tready_low", in_tready, 0);
    out_tready = 1'b1;
    #1;
    chk("in_tready_high", in_tready, 1);
    ready_mode = 1;

    // Untimed 100 pushed after beat 3 of 8: applies on the next packet only.
    send_packet(8, 1'b0, 64'd0, 2, 16'd100, 1'b0, 1'b0);
    send_packet(4, 1'b0, 64'd0, -1, 16'd0, 1'b0, 1'b0);

    // Timed T=1000: 900 and untimed-packet do not apply; 1000 applies on time.
    push_cmd(1'b1, 64'd1000, 16'd7);
    send_packet(2, 1'b1, 64'd900, -1, 16'd0, 1'b0, 1'b0);
    send_packet(2, 1'b0, 64'd5000, -1, 16'd0, 1'b0, 1'b0);
    send_packet(2, 1'b1, 64'd1000, -1, 16'd0, 1'b0, 1'b0);
    push_cmd(1'b1, 64'd1000, 16'd9);
    send_packet(2, 1'b1, 64'd1005, -1, 16'd0, 1'b0, 1'b0);

    // Three back-to-back untimed commands on one packet.
    push_cmd(1'b0, 64'd0, 16'd5);
    push_cmd(1'b0, 64'd0, 16'd6);
    push_cmd(1'b0, 64'd0, 16'd7);
    send_packet(3, 1'b0, 64'd0, -1, 16'd0, 1'b0, 1'b0);

    // Fill the queue, refuse the ninth push, then push during an apply.
    for (int k = 0; k < 9; k++) push_cmd(1'b0, 64'd0, 16'(20 + k));
    chk("count_full", queue_count, DEPTH);
    chk("cmd_ready_full", cmd_ready, 0);
    send_packet(2, 1'b0, 64'd0, -1, 16'd0, 1'b0, 1'b1);

    // Flush with an eligible first beat in the same cycle.
    for (int k = 0; k < 4; k++) push_cmd(1'b0, 64'd0, 16'(40 + k));
    chk("count_before_flush", queue_count, 4);
    send_packet(3, 1'b0, 64'd0, -1, 16'd0, 1'b1, 1'b0);

    // Random commands and packets with random downstream backpressure.
    ready_mode = 2;
    for (int r = 0; r < 40; r++) begin
      int np;
      np = $urandom_range(0, 3);
      for (int k = 0; k < np; k++) begin
        if ($urandom_range(0, 2) == 0)
          push_cmd(1'b1, 64'($urandom_range(0, 2000)), 16'($urandom));
        else
          push_cmd(1'b0, 64'd0, 16'($urandom));
      end
      send_packet($urandom_range(1, 6), 1'($urandom_range(0, 3) != 0),
                  64'($urandom_range(0, 2000)), -1, 16'd0, 1'b0, 1'b0);
      chk("random_count", queue_count, mq.size());
    end

    ready_mode = 1;
    repeat (5) step();
    chk("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
